// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_e          : sequencer states
//   KCNT_W           : width of the post-redirect kill counter
//   load_use_hazard(): detects an IF/ID source that depends on a load in EX
package pipe_ctrl_pkg;

    localparam int KCNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_e;

    // x0 never carries a real dependency, so a load into x0 never stalls.
    function automatic logic load_use_hazard(
        input logic       ex_is_load,
        input logic [4:0] ex_rd,
        input logic       id_use_rs1,
        input logic [4:0] id_rs1,
        input logic       id_use_rs2,
        input logic [4:0] id_rs2
    );
        return ex_is_load && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the sequencer's performance counters.
//   clk   : core clock
//   rst_n : asynchronous active-low reset, clears count
//   clr   : synchronous clear, takes priority over inc
//   inc   : increment by one unless already all-ones
//   cnt   : current count
module pipe_ctrl_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer for the 3-stage core (IF/ID -> EX -> WB).
// Handles hazards the forwarding unit cannot bypass: load-use, I$/D$ miss and
// taken-branch/jump redirects. Control outputs are combinational from state
// and inputs; state and perf counters are registered.
//
// Ports
//   clk, rst_n                 : core clock, async active-low reset
//   id_rs1/id_rs2, id_use_rs*  : source registers of the IF/ID instruction
//   ex_rd, ex_is_load          : destination / load flag of the EX instruction
//   ex_redirect                : EX resolved a taken branch / JAL / JALR
//   icache_stall, dcache_stall : fetch data / data access not ready
//   cnt_clr                    : synchronous clear of both perf counters
//   pc_stall, ifid_stall       : hold PC / IF/ID register
//   ifid_kill, idex_bubble     : load NOP into IF/ID / into EX
//   ex_freeze                  : hold EX and WB, suppress regfile write
//   stall_cnt, flush_cnt       : saturating counts of stalled cycles / redirects
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | normal flow, load-use detection active
// ST_LDSTALL | one-cycle load-use bubble issued, return to RUN next cycle
// ST_FLUSH   | killing wrong-path fetch slots, kcnt slots remaining
// ST_MEMWAIT | D$ stall, whole pipe frozen; prior state/kcnt saved
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_kill,
    output logic             idex_bubble,
    output logic             ex_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [KCNT_W-1:0] KCNT_RELOAD = KCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [KCNT_W-1:0] KCNT_ONE    = KCNT_W'(1);

    state_e            state_q, state_d;
    state_e            sv_state_q, sv_state_d;
    logic [KCNT_W-1:0] kcnt_q, kcnt_d;
    logic [KCNT_W-1:0] sv_kcnt_q, sv_kcnt_d;
    state_e            eff_state;
    logic [KCNT_W-1:0] eff_kcnt;
    logic              load_use;
    logic              flush_inc;

    assign load_use = load_use_hazard(ex_is_load, ex_rd, id_use_rs1, id_rs1,
                                      id_use_rs2, id_rs2);

    always_comb begin
        state_d     = state_q;
        kcnt_d      = kcnt_q;
        sv_state_d  = sv_state_q;
        sv_kcnt_d   = sv_kcnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_kill   = 1'b0;
        idex_bubble = 1'b0;
        ex_freeze   = 1'b0;
        flush_inc   = 1'b0;

        // Leaving MEMWAIT resumes the saved context in the same cycle.
        eff_state = state_q;
        eff_kcnt  = kcnt_q;
        if (state_q == ST_MEMWAIT) begin
            eff_state = sv_state_q;
            eff_kcnt  = sv_kcnt_q;
        end

        if (dcache_stall) begin
            // A redirect seen here is still held in EX and re-presents on exit.
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            ex_freeze  = 1'b1;
            state_d    = ST_MEMWAIT;
            if (state_q != ST_MEMWAIT) begin
                sv_state_d = state_q;
                sv_kcnt_d  = kcnt_q;
            end
        end else if (ex_redirect) begin
            // Any same-cycle load-use belongs to the wrong path and is dropped.
            ifid_kill   = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                kcnt_d  = KCNT_RELOAD;
            end else begin
                state_d = ST_RUN;
                kcnt_d  = '0;
            end
        end else begin
            state_d = eff_state;
            kcnt_d  = eff_kcnt;
            if (eff_state == ST_FLUSH) begin
                ifid_kill = 1'b1;
                if (icache_stall) begin
                    // No valid fetch this slot, so it does not count as killed.
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (eff_kcnt <= KCNT_ONE) begin
                    kcnt_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    kcnt_d = eff_kcnt - KCNT_ONE;
                end
            end else if (icache_stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end else if (eff_state == ST_LDSTALL) begin
                state_d = ST_RUN;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                state_d     = ST_LDSTALL;
            end
        end

        if (!rst_n) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b0;
            ifid_kill   = 1'b1;
            idex_bubble = 1'b0;
            ex_freeze   = 1'b0;
            flush_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            kcnt_q     <= '0;
            sv_state_q <= ST_RUN;
            sv_kcnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            kcnt_q     <= kcnt_d;
            sv_state_q <= sv_state_d;
            sv_kcnt_q  <= sv_kcnt_d;
        end
    end

    pipe_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (pc_stall),
        .cnt   (stall_cnt)
    );

    pipe_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (flush_inc),
        .cnt   (flush_cnt)
    );

endmodule
